// File: rtl/better_qvalue_writer_pkg.sv
// Shared constants, state encoding and address helpers for better_qvalue_writer.
// The optional tolerance compare (BQW_TOLERANCE_EN) lives in bq_compare only.
package better_qvalue_writer_pkg;

  localparam logic [15:0] BQ_LIST_BASE   = 16'h710;
  localparam logic [15:0] BQ_LEN_ADDR    = 16'h720;
  localparam int          BQ_MAX_ENTRIES = 16;
  localparam logic [15:0] TOLERANCE      = 16'd1;

  // Count must hold 0..BQ_MAX_ENTRIES inclusive, hence one extra bit.
  localparam int                 COUNT_W      = $clog2(BQ_MAX_ENTRIES) + 1;
  localparam logic [COUNT_W-1:0] BQ_MAX_COUNT = COUNT_W'(BQ_MAX_ENTRIES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_WRITE_LEN = 3'd3,
    ST_DONE      = 3'd4
  } bq_state_e;

  function automatic logic [15:0] bq_widen_count(input logic [COUNT_W-1:0] cnt);
    return {{(16-COUNT_W){1'b0}}, cnt};
  endfunction

  function automatic logic [15:0] bq_entry_addr(input logic [COUNT_W-1:0] idx);
    return BQ_LIST_BASE + bq_widen_count(idx);
  endfunction

endpackage

// File: rtl/bq_compare.sv
// Candidate qualification compare; BQW_TOLERANCE_EN selects the tolerant form.
// Purely combinational so the writer sees the verdict in the accept cycle.
module bq_compare
  import better_qvalue_writer_pkg::*;
(
  input  logic [15:0] qvalue,
  input  logic [15:0] threshold,
  output logic        qualifies
);

`ifdef BQW_TOLERANCE_EN
  // 17-bit sum so qvalue near 16'hFFFF cannot wrap below the threshold.
  logic [16:0] tolerant_sum;
  assign tolerant_sum = {1'b0, qvalue} + {1'b0, TOLERANCE};
  assign qualifies    = (tolerant_sum >= {1'b0, threshold});
`else
  assign qualifies = (qvalue >= threshold);
`endif

endmodule

// File: rtl/better_qvalue_writer.sv
// Builds a list of qualifying neighbor IDs at 0x710.. and its length at 0x720.
// Optional build macro BQW_TOLERANCE_EN relaxes the compare (see bq_compare).
module better_qvalue_writer
  import better_qvalue_writer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bestvalue,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_qvalue,
  input  logic [15:0] in_id,
  input  logic        in_last,
  output logic [15:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  cstate
);

  bq_state_e          state_reg;
  logic [15:0]        best_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               overflow_reg;
  logic               wr_en_reg;
  logic [15:0]        address_reg;
  logic [15:0]        data_out_reg;
  logic               done_reg;
  logic               qualifies;
  logic               accept;

  bq_compare u_compare (
    .qvalue    (in_qvalue),
    .threshold (best_reg),
    .qualifies (qualifies)
  );

  assign in_ready = (state_reg == ST_COLLECT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      best_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      address_reg  <= '0;
      data_out_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            best_reg     <= bestvalue;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (qualifies) begin
              if (count_reg != BQ_MAX_COUNT) begin
                wr_en_reg    <= 1'b1;
                address_reg  <= bq_entry_addr(count_reg);
                data_out_reg <= in_id;
                count_reg    <= count_reg + 1'b1;
              end else begin
                overflow_reg <= 1'b1;
              end
            end
            if (in_last) begin
              state_reg <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Any final entry write is on the bus now; queue the length word.
          wr_en_reg    <= 1'b1;
          address_reg  <= BQ_LEN_ADDR;
          data_out_reg <= bq_widen_count(count_reg);
          state_reg    <= ST_WRITE_LEN;
        end
        ST_WRITE_LEN: begin
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign address  = address_reg;
  assign data_out = data_out_reg;
  assign wr_en    = wr_en_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;
  assign cstate   = {5'b0, state_reg};

endmodule

// File: tb/tb_better_qvalue_writer.sv
// Directed bench for better_qvalue_writer: logs bus writes and checks them
// against hand-computed lists, plus latency, done, overflow and reset state.
module tb_better_qvalue_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bestvalue;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_qvalue;
  logic [15:0] in_id;
  logic        in_last;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wr_en;
  logic        done;
  logic        overflow;
  logic [7:0]  cstate;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Write log and accept log, filled by the negedge monitor.
  logic [15:0] wa [$];
  logic [15:0] wd [$];
  int          wc [$];
  int          ac [$];
  int          dcount;
  int          done_cyc;

  // Candidate table and expected write list for the current build.
  logic [15:0] qv  [0:31];
  logic [15:0] idv [0:31];
  logic [15:0] exp_a [$];
  logic [15:0] exp_d [$];

  better_qvalue_writer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bestvalue (bestvalue),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_qvalue (in_qvalue),
    .in_id     (in_id),
    .in_last   (in_last),
    .address   (address),
    .data_out  (data_out),
    .wr_en     (wr_en),
    .done      (done),
    .overflow  (overflow),
    .cstate    (cstate)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (in_valid && in_ready) ac.push_back(cyc);
    if (wr_en) begin
      wa.push_back(address);
      wd.push_back(data_out);
      wc.push_back(cyc);
    end
    if (done) begin
      dcount++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); ac.delete();
    exp_a.delete(); exp_d.delete();
    dcount = 0;
    done_cyc = -1;
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  // Runs one build of n candidates; toggle inserts an idle cycle with a start pulse after each accept.
  task automatic build(input string name, input logic [15:0] bv, input int n, input bit toggle);
    int t;
    bestvalue = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_qvalue = qv[i];
      in_id     = idv[i];
      in_last   = (i == n - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        step();
        t++;
      end
      if (!in_ready) check({name, " ready_timeout"}, 32'd0, 32'd1);
      step();
      if (toggle) begin
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    t = 0;
    while (dcount == 0 && t < 40) begin
      step();
      t++;
    end
    step();
    check({name, " done_count"}, dcount, 1);
  endtask

  // Compares the write log with the expected list and checks last-candidate latency.
  task automatic verify(input string name);
    int last_acc;
    check({name, " n_writes"}, wa.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), wa[i], exp_a[i]);
      check($sformatf("%s data[%0d]", name, i), wd[i], exp_d[i]);
    end
    last_acc = (ac.size() > 0) ? ac[ac.size()-1] : -100;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] == 16'h720)
        check({name, " len_latency"}, wc[i], last_acc + 2);
      else
        check($sformatf("%s entry_latency[%0d]", name, i), (wc[i] - 1) inside {ac}, 1);
    end
    check({name, " done_latency"}, done_cyc, last_acc + 3);
    $display("build %s: %0d writes, overflow=%0b", name, wa.size(), overflow);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bestvalue = '0;
    in_valid = 1'b0; in_qvalue = '0; in_id = '0; in_last = 1'b0;
    clear_logs();
    step(); step();
    check("rst wr_en", wr_en, 0);
    check("rst cstate", cstate, 0);
    check("rst in_ready", in_ready, 0);
    check("rst addr", address, 0);
    check("rst data", data_out, 0);
    check("rst done", done, 0);
    check("rst overflow", overflow, 0);
    reset = 1'b0;
    step();
    check("idle in_ready", in_ready, 0);

    // Mixed build: 60 and 50 qualify against 50, 40 does not.
    clear_logs();
    qv[0] = 16'd60; idv[0] = 16'd3;
    qv[1] = 16'd40; idv[1] = 16'd7;
    qv[2] = 16'd50; idv[2] = 16'd9;
    expect_write(16'h710, 16'd3);
    expect_write(16'h711, 16'd9);
    expect_write(16'h720, 16'd2);
    build("basic", 16'd50, 3, 1'b0);
    verify("basic");
    check("basic overflow", overflow, 0);
    check("basic idle", cstate, 0);

    // Empty build.
    clear_logs();
    qv[0] = 16'd10; idv[0] = 16'd4;
    expect_write(16'h720, 16'd0);
    build("empty", 16'd100, 1, 1'b0);
    verify("empty");

    // 18 qualifiers: two dropped, list saturates at 16.
    clear_logs();
    for (int i = 0; i < 18; i++) begin
      qv[i]  = 16'(i * 7);
      idv[i] = 16'(i + 1);
      if (i < 16) expect_write(16'h710 + 16'(i), 16'(i + 1));
    end
    expect_write(16'h720, 16'd16);
    build("full", 16'd0, 18, 1'b0);
    verify("full");
    check("full overflow", overflow, 1);

    // Reset two cycles after the first entry write.
    clear_logs();
    bestvalue = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    check("new start clears overflow", overflow, 0);
    in_valid = 1'b1; in_qvalue = 16'd5; in_id = 16'd1; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    check("mid wr_en", wr_en, 1);
    check("mid addr", address, 16'h710);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst wr_en", wr_en, 0);
    check("midrst cstate", cstate, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst addr", address, 0);
    check("midrst done", done, 0);
    for (int i = 0; i < 6; i++) step();
    check("midrst no_len", 16'h720 inside {wa}, 0);
    check("midrst no_done", dcount, 0);

    // Clean rebuild after the reset.
    clear_logs();
    qv[0] = 16'd60; idv[0] = 16'd3;
    qv[1] = 16'd40; idv[1] = 16'd7;
    qv[2] = 16'd50; idv[2] = 16'd9;
    expect_write(16'h710, 16'd3);
    expect_write(16'h711, 16'd9);
    expect_write(16'h720, 16'd2);
    build("rebuild", 16'd50, 3, 1'b0);
    verify("rebuild");

    // One below the threshold: qualifies only with tolerance.
    clear_logs();
    qv[0] = 16'd49; idv[0] = 16'd5;
`ifdef BQW_TOLERANCE_EN
    expect_write(16'h710, 16'd5);
    expect_write(16'h720, 16'd1);
`else
    expect_write(16'h720, 16'd0);
`endif
    build("tol", 16'd50, 1, 1'b0);
    verify("tol");

    // Gapped in_valid with start pulses mid-build; 19 < 20 is rejected either way.
    clear_logs();
    qv[0] = 16'd25;    idv[0] = 16'd11;
    qv[1] = 16'd18;    idv[1] = 16'd12;
    qv[2] = 16'd20;    idv[2] = 16'd13;
    qv[3] = 16'hFFFF;  idv[3] = 16'd14;
    expect_write(16'h710, 16'd11);
    expect_write(16'h711, 16'd13);
    expect_write(16'h712, 16'd14);
    expect_write(16'h720, 16'd3);
    build("toggle", 16'd20, 4, 1'b1);
    verify("toggle");
    check("toggle overflow", overflow, 0);
    check("toggle idle", cstate, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
